// File: rtl/divu_pkg.sv
// Shared constants and state encoding for the 32-bit restoring divider.
package divu_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } divu_state_e;

endpackage

// File: rtl/subtract_32_bit.sv
// 32-bit subtractor: diff = a - b, cout = 1 when no borrow occurs (a >= b).
module subtract_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        cout
);

    logic [32:0] sum;

    // Two's-complement add; the carry out is the inverted borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        diff = sum[31:0];
        cout = sum[32];
    end

endmodule

// File: rtl/divu_32_bit_ctrl.sv
// Unsigned 32-bit restoring divider: one quotient bit per cycle, 32 RUN cycles per divide.
module divu_32_bit_ctrl
    import divu_pkg::*;
#(
    parameter int unsigned DW = divu_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero
);

    divu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    r_q, r_d;
    logic [DW-1:0]    q_q, q_d;
    logic [DW-1:0]    dvsr_q, dvsr_d;
    logic [DW-1:0]    quot_q, quot_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [DW-1:0]    p;
    logic [DW-1:0]    diff;
    logic             cout;
    logic             qbit;
    logic [DW-1:0]    r_step;
    logic [DW-1:0]    q_step;

    // Shift the next dividend bit into the partial remainder.
    assign p = {r_q[DW-2:0], q_q[DW-1]};

    subtract_32_bit u_sub (
        .a    (p),
        .b    (dvsr_q),
        .diff (diff),
        .cout (cout)
    );

    // When R[31] is set the true partial remainder is 33 bits and always exceeds the
    // divisor, so the subtract succeeds and the 32-bit difference is still exact.
    always_comb begin
        qbit   = r_q[DW-1] | cout;
        r_step = qbit ? diff : p;
        q_step = {q_q[DW-2:0], qbit};
    end

    // Next-state, datapath and result register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        dvsr_d  = divisor;
                        dz_d    = 1'b0;
                        cnt_d   = '0;
                        r_d     = '0;
                        q_d     = dividend;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                r_d = r_step;
                q_d = q_step;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    cnt_d   = '0;
                    quot_d  = q_step;
                    rem_d   = r_step;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Status decoded purely from state; results straight from their registers.
    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        quotient  = quot_q;
        remainder = rem_q;
        div_zero  = dz_q;
    end

endmodule
